// File: rtl/carrier_mixer_pkg.sv
// Shared acquisition constants: sin/cos word layout, IQ packing and output
// saturation limits used by the carrier wipeoff mixer.
package carrier_mixer_pkg;
    localparam int COS_LSB = 0;
    localparam int SIN_LSB = 8;
    localparam int SC_W    = 8;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    localparam int I_LSB   = 0;
    localparam int Q_LSB   = 16;
endpackage

// File: rtl/carrier_mixer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_cnt;
    logic             w_push, w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign level  = r_cnt;
    assign rdata  = r_mem[r_rptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear) r_mem[r_wptr] <= wdata;
    end
endmodule

// File: rtl/carrier_mixer.sv
// Rotates baseband IQ samples by the buffered CORDIC sin/cos stream
// (multiply by e^-jθ) and frames the products per bin with tlast.
module carrier_mixer
    import carrier_mixer_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int SINCOS_WIDTH  = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int SHIFT         = 6,
    parameter int BIN_LEN_WIDTH = 16
) (
    input  logic                          axis_aclk,
    input  logic                          axis_aresetn,
    input  logic                          clear,
    input  logic [BIN_LEN_WIDTH-1:0]      bin_len,
    input  logic [SINCOS_WIDTH-1:0]       sincos_data,
    input  logic                          sincos_valid,
    input  logic [2*SAMPLE_WIDTH-1:0]     s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [2*SAMPLE_WIDTH-1:0]     m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int STAGES = 3;
    localparam int PROD_W = SAMPLE_WIDTH + 8;
    localparam int SUM_W  = SAMPLE_WIDTH + 9;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(SAT_MAX);
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(SAT_MIN);

    logic                           w_adv, w_acc, w_full, w_empty, w_drop, w_last;
    logic [SINCOS_WIDTH-1:0]        w_sc;
    logic signed [SC_W-1:0]         w_cos, w_sin;
    logic signed [SAMPLE_WIDTH-1:0] w_i, w_q;
    logic [BIN_LEN_WIDTH-1:0]       r_cnt, r_len, w_len;
    logic [STAGES:1]                r_vld_pipe;
    logic signed [PROD_W-1:0]       r_p_ic, r_p_qs, r_p_qc, r_p_is;
    logic signed [SUM_W-1:0]        r_s_i, r_s_q;
    logic                           r_last1, r_last2;

    function automatic logic [SAMPLE_WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] s;
        s = v >>> SHIFT;
        if (s > SAT_HI)      return SAT_HI[SAMPLE_WIDTH-1:0];
        else if (s < SAT_LO) return SAT_LO[SAMPLE_WIDTH-1:0];
        else                 return s[SAMPLE_WIDTH-1:0];
    endfunction

    assign w_adv         = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = w_adv && !w_empty && !clear;
    assign w_acc         = s_axis_tvalid && s_axis_tready;
    assign w_drop        = sincos_valid && w_full && !w_acc && !clear;
    assign m_axis_tvalid = r_vld_pipe[STAGES];

    sync_fifo #(.WIDTH(SINCOS_WIDTH), .DEPTH(FIFO_DEPTH)) u_sc_fifo (
        .clk   (axis_aclk),
        .rst_n (axis_aresetn),
        .push  (sincos_valid && !clear),
        .pop   (w_acc),
        .clear (clear),
        .wdata (sincos_data),
        .rdata (w_sc),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign w_cos = w_sc[COS_LSB +: SC_W];
    assign w_sin = w_sc[SIN_LSB +: SC_W];
    assign w_i   = s_axis_tdata[I_LSB +: SAMPLE_WIDTH];
    assign w_q   = s_axis_tdata[Q_LSB +: SAMPLE_WIDTH];

    // bin length is latched at the first sample of each bin; 0 means 1
    assign w_len  = (r_cnt == '0) ? ((bin_len == '0) ? BIN_LEN_WIDTH'(1) : bin_len) : r_len;
    assign w_last = (r_cnt == w_len - BIN_LEN_WIDTH'(1));

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_cnt    <= '0;
            r_len    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            r_cnt    <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_drop) overflow <= 1'b1;
            if (w_acc) begin
                r_cnt <= w_last ? '0 : r_cnt + BIN_LEN_WIDTH'(1);
                if (r_cnt == '0) r_len <= w_len;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn)  r_vld_pipe <= '0;
        else if (clear)     r_vld_pipe <= '0;
        else if (w_adv)     r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_p_ic       <= '0;
            r_p_qs       <= '0;
            r_p_qc       <= '0;
            r_p_is       <= '0;
            r_s_i        <= '0;
            r_s_q        <= '0;
            r_last1      <= 1'b0;
            r_last2      <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else if (w_adv) begin
            r_p_ic       <= PROD_W'(w_i) * PROD_W'(w_cos);
            r_p_qs       <= PROD_W'(w_q) * PROD_W'(w_sin);
            r_p_qc       <= PROD_W'(w_q) * PROD_W'(w_cos);
            r_p_is       <= PROD_W'(w_i) * PROD_W'(w_sin);
            r_last1      <= w_last;
            r_s_i        <= SUM_W'(r_p_ic) + SUM_W'(r_p_qs);
            r_s_q        <= SUM_W'(r_p_qc) - SUM_W'(r_p_is);
            r_last2      <= r_last1;
            m_axis_tdata <= {sat(r_s_q), sat(r_s_i)};
            m_axis_tlast <= r_last2;
        end
    end
endmodule

// File: tb/tb_carrier_mixer.sv
// Scoreboard bench for carrier_mixer: a negedge monitor models the sin/cos
// buffer, bin framing and complex rotation, and checks every output beat.
module tb_carrier_mixer;
    logic        axis_aclk     = 1'b0;
    logic        axis_aresetn  = 1'b1;
    logic        clear         = 1'b0;
    logic [15:0] bin_len       = 16'd4;
    logic [15:0] sincos_data   = '0;
    logic        sincos_valid  = 1'b0;
    logic [31:0] s_axis_tdata  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        overflow;
    logic [4:0]  fifo_level;

    carrier_mixer dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .clear         (clear),
        .bin_len       (bin_len),
        .sincos_data   (sincos_data),
        .sincos_valid  (sincos_valid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    always #5 axis_aclk = ~axis_aclk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sc_q[$];
    int          m_cnt = 0, m_len = 1;
    bit          m_ovf = 0;
    bit          stalled_prev = 0;
    logic [31:0] held_d = '0;
    logic        held_l = 1'b0;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    // e^-jθ rotation done in plain integer arithmetic
    function automatic logic [31:0] rotate(input logic [31:0] smp, input logic [15:0] sc);
        int i, q, c, s, ii, qq;
        i  = $signed(smp[15:0]);
        q  = $signed(smp[31:16]);
        c  = $signed(sc[7:0]);
        s  = $signed(sc[15:8]);
        ii = (i * c + q * s) >>> 6;
        qq = (q * c - i * s) >>> 6;
        return {sat16(qq), sat16(ii)};
    endfunction

    function automatic logic [31:0] pk(input int i, input int q);
        return {16'(q), 16'(i)};
    endfunction

    always @(negedge axis_aclk) begin
        if (!axis_aresetn) begin
            exp_q.delete();
            sc_q.delete();
            m_cnt = 0;
            m_ovf = 0;
            stalled_prev = 0;
        end else begin
            chk("fifo_level", fifo_level, sc_q.size());
            chk("overflow", overflow, m_ovf);
            if (stalled_prev) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", {m_axis_tlast, m_axis_tdata}, {held_l, held_d});
            end
            chk("s_tready", s_axis_tready,
                (!m_axis_tvalid || m_axis_tready) && sc_q.size() > 0 && !clear);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_order: actual beat %0h required no beat", m_axis_tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, e.data);
                    chk("out_last", m_axis_tlast, e.last);
                end
            end
            stalled_prev = m_axis_tvalid && !m_axis_tready;
            held_d = m_axis_tdata;
            held_l = m_axis_tlast;
            if (clear) begin
                exp_q.delete();
                sc_q.delete();
                m_cnt = 0;
                m_ovf = 0;
                stalled_prev = 0;
            end else begin
                if (s_axis_tvalid && s_axis_tready) begin
                    if (sc_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL accept_empty: actual accept required no accept");
                    end else begin
                        exp_t e;
                        logic [15:0] sc;
                        sc = sc_q.pop_front();
                        if (m_cnt == 0) m_len = (bin_len == 0) ? 1 : int'(bin_len);
                        e.data = rotate(s_axis_tdata, sc);
                        e.last = (m_cnt + 1 == m_len);
                        m_cnt  = e.last ? 0 : m_cnt + 1;
                        exp_q.push_back(e);
                    end
                end
                if (sincos_valid) begin
                    if (sc_q.size() < 16) sc_q.push_back(sincos_data);
                    else m_ovf = 1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        logic hs;
        int   n;
        hs = 0;
        n  = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge axis_aclk);
            hs = s_axis_tready;
            sync();
            n++;
        end
        if (!hs) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: actual no accept required accept within 200 cycles");
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic push_sc(input logic [15:0] w, input int n);
        sincos_data  = w;
        sincos_valid = 1'b1;
        repeat (n) sync();
        sincos_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        sync();
        clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
            sync();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_tready", s_axis_tready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 axis_aresetn = 1'b0;
        #10 chk_reset();
        sync();
        axis_aresetn = 1'b1;
        sync();

        // zero phase, bin of 4, plus exact 3-cycle latency on a lone sample
        bin_len = 16'd4;
        push_sc(16'h0040, 4);
        send(pk(1000, -500));
        @(negedge axis_aclk) chk("lat_c1", m_axis_tvalid, 0);
        @(negedge axis_aclk) chk("lat_c2", m_axis_tvalid, 0);
        @(negedge axis_aclk) chk("lat_c3", m_axis_tvalid, 1);
        sync();
        repeat (3) send(pk(1000, -500));
        drain();

        // 90 degrees and saturation
        pulse_clear();
        push_sc(16'h4000, 1);
        send(pk(1000, 200));
        push_sc(16'h4040, 1);
        send(pk(32767, 32767));
        push_sc(16'hC080, 1);
        send(pk(-32768, 32767));
        drain();

        // randomized traffic with a forced 5-cycle output stall
        pulse_clear();
        fork
            begin
                for (int k = 0; k < 500; k++) begin
                    sincos_valid = ($urandom % 3) != 0;
                    sincos_data  = 16'($urandom);
                    sync();
                end
            end
            begin
                logic hs;
                hs = 0;
                for (int k = 0; k < 500; k++) begin
                    if (!s_axis_tvalid || hs) begin
                        s_axis_tvalid = ($urandom % 4) != 0;
                        s_axis_tdata  = $urandom;
                    end
                    @(negedge axis_aclk);
                    hs = s_axis_tvalid && s_axis_tready;
                    sync();
                end
            end
            begin
                for (int k = 0; k < 500; k++) begin
                    m_axis_tready = (k >= 100 && k < 105) ? 1'b0 : (($urandom % 4) != 0);
                    sync();
                end
            end
            begin
                for (int k = 0; k < 500; k++) begin
                    if ($urandom % 40 == 0) bin_len = 16'($urandom_range(0, 6));
                    sync();
                end
            end
        join
        s_axis_tvalid = 1'b0;
        sincos_valid  = 1'b0;
        m_axis_tready = 1'b1;
        drain();

        // overflow with a stalled pipeline, then clear
        pulse_clear();
        m_axis_tready = 1'b0;
        bin_len = 16'd5;
        push_sc(16'h0040, 2);
        send(pk(100, 1));
        send(pk(200, 2));
        push_sc(16'h1234, 20);
        @(negedge axis_aclk);
        chk("ovf_level", fifo_level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_tvalid", m_axis_tvalid, 1);
        sync();
        pulse_clear();
        @(negedge axis_aclk);
        chk("clr_level", fifo_level, 0);
        chk("clr_flag", overflow, 0);
        chk("clr_tvalid", m_axis_tvalid, 0);
        sync();
        m_axis_tready = 1'b1;
        bin_len = 16'd3;
        push_sc(16'h0040, 3);
        repeat (3) send(pk(300, -7));
        drain();

        // asynchronous reset during a bin
        bin_len = 16'd4;
        push_sc(16'h0040, 4);
        send(pk(11, 22));
        send(pk(33, 44));
        @(posedge axis_aclk);
        #3 axis_aresetn = 1'b0;
        #1 chk_reset();
        sync();
        sync();
        axis_aresetn = 1'b1;
        push_sc(16'h2030, 4);
        repeat (4) send(pk(-1234, 4321));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
